bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single MemoryUnit bus (addr/data/we/start/q/done handshake) between two bus masters: CPU (m0) and a future DMA/blitter master (m1).
- Sits between the masters and MemoryUnit in the FPGC5 top level, on the system clock (50 MHz).
- Latches one pending request per master, grants round-robin, issues one transaction at a time and routes the result back.
- A watchdog aborts transactions whose slave never returns done.

Parameters:
- TIMEOUT, 1023: cycles to wait for bus_done after bus_start before aborting. 0 disables the watchdog.
- TIMEOUT_W, 10: width of the watchdog counter. Must satisfy 2^TIMEOUT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- m0_addr  in  27  master 0 address
- m0_data  in  32  master 0 write data
- m0_we  in  1  master 0 write enable
- m0_start  in  1  master 0 request pulse (1 cycle)
- m0_q  out  32  master 0 read data
- m0_done  out  1  master 0 completion pulse (1 cycle)
- m1_addr  in  27  master 1 address
- m1_data  in  32  master 1 write data
- m1_we  in  1  master 1 write enable
- m1_start  in  1  master 1 request pulse (1 cycle)
- m1_q  out  32  master 1 read data
- m1_done  out  1  master 1 completion pulse (1 cycle)
- bus_addr  out  27  to MemoryUnit
- bus_data  out  32  to MemoryUnit
- bus_we  out  1  to MemoryUnit
- bus_start  out  1  to MemoryUnit, 1-cycle pulse
- bus_q  in  32  from MemoryUnit
- bus_done  in  1  from MemoryUnit, 1-cycle pulse
- grant  out  1  index of master owning the current or last transaction
- timeout_err  out  1  1-cycle pulse when a transaction is aborted

Behaviour:
- Reset (nreset low, asynchronous):
  - All outputs 0; FSM goes to IDLE.
  - Both pending flags cleared; watchdog cleared.
  - last_grant = 1, so master 0 wins the first tie.
  - Reset mid-transaction abandons it; no done is generated.
- Request capture:
  - On mX_start, while master X has no pending request, latch addr/data/we into a per-master holding register and set pending[X].
  - Capture is independent of FSM state, so a master may post while the other master's transaction is in flight.
  - mX_start while pending[X] is already set is ignored: the register is not overwritten and no done is generated for it.
- FSM:
  - IDLE: if any pending flag is set, select the requester. With one pending, take it. With both pending, take ~last_grant.
  - Transition IDLE -> ISSUE on the cycle after selection.
  - A request captured in cycle T can be selected in cycle T+1.
- ISSUE (1 cycle):
  - Drive bus_addr/bus_data/bus_we from the selected holding register and pulse bus_start.
  - Set grant = last_grant = selected master; clear that pending flag.
  - Load the watchdog with 0; go to WAIT.
  - Minimum latency with the bus idle: mX_start at cycle 0 -> bus_start at cycle 2.
- WAIT:
  - bus_addr/data/we stay stable; the watchdog increments each cycle.
  - On bus_done: register bus_q into m[grant]_q and pulse m[grant]_done in the next cycle; go to IDLE.
  - A new grant may be issued no earlier than the cycle after done is returned.
  - The other master's q and done are untouched.
  - When TIMEOUT != 0 and the watchdog reaches TIMEOUT with no bus_done: pulse m[grant]_done with m[grant]_q = 32'h0, pulse timeout_err, go to IDLE.
- Stray done: bus_done in IDLE or ISSUE is ignored.
- mX_q holds its last value until that master's next done.
- Simultaneous events:
  - bus_done and the timeout in the same cycle: done wins, no timeout_err.
  - mX_start in the same cycle as that master's done: accepted as a new request.

Test Plan:
- Single read, m0: m0_start with addr 27'h000100, we=0; slave returns q=32'hCAFEBABE 3 cycles after bus_start -> bus_start 2 cycles after m0_start, bus_addr 27'h000100; m0_done one cycle after bus_done with m0_q=32'hCAFEBABE; m1_done stays 0.
- Tie arbitration after reset: m0_start and m1_start in the same cycle -> master 0 is served first (grant=0); master 1 is issued after m0_done; a subsequent tie is served master 0 first, alternating thereafter.
- Posting during a transaction: m1 writes addr 27'h0000FF, data 32'h12345678 while an m0 transaction is in WAIT -> m1 values captured; bus_addr and bus_data remain m0's until m0 completes, then bus_we=1 with m1's values is issued.
- Duplicate start: m0_start twice while pending -> exactly one bus_start and one m0_done carrying the first address.
- Timeout: TIMEOUT=8, slave never asserts done -> m0_done and timeout_err pulse 8 cycles after bus_start, m0_q=0; a late bus_done is then ignored.
- Reset mid-WAIT: nreset low during WAIT -> all outputs immediately 0, no done afterward; the next m1_start is served normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the MemoryUnit bus between two masters.
// Round-robin grant, one transaction in flight, watchdog abort.
module bus_arbiter #(
  parameter int TIMEOUT   = 1023,
  parameter int TIMEOUT_W = 10
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [26:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic [31:0] m0_q,
  output logic        m0_done,
  input  logic [26:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic [31:0] m1_q,
  output logic        m1_done,
  output logic [26:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [TIMEOUT_W:0] TO_LIM =
    TIMEOUT[TIMEOUT_W:0];

  state_t               state;
  logic [1:0]           pending;
  logic [26:0]          h_addr [2];
  logic [31:0]          h_data [2];
  logic [1:0]           h_we;
  logic                 last_grant;
  logic [TIMEOUT_W-1:0] wd;
  logic [TIMEOUT_W:0]   wd_nxt;
  logic                 sel;
  logic                 to_hit;

  assign sel    = (&pending) ? ~last_grant
                             : pending[1];
  assign wd_nxt = {1'b0, wd} + (TIMEOUT_W+1)'(1);
  assign to_hit = (TIMEOUT != 0) &&
                  (wd_nxt >= TO_LIM);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      pending     <= '0;
      h_addr[0]   <= '0;
      h_addr[1]   <= '0;
      h_data[0]   <= '0;
      h_data[1]   <= '0;
      h_we        <= '0;
      last_grant  <= 1'b1;
      wd          <= '0;
      grant       <= 1'b0;
      bus_addr    <= '0;
      bus_data    <= '0;
      bus_we      <= 1'b0;
      bus_start   <= 1'b0;
      m0_q        <= '0;
      m1_q        <= '0;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      bus_start   <= 1'b0;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      timeout_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (|pending) begin
            state        <= ISSUE;
            bus_addr     <= h_addr[sel];
            bus_data     <= h_data[sel];
            bus_we       <= h_we[sel];
            bus_start    <= 1'b1;
            grant        <= sel;
            last_grant   <= sel;
            pending[sel] <= 1'b0;
            wd           <= '0;
          end
        end
        ISSUE: begin
          // counting from the bus_start cycle puts the
          // abort pulse exactly TIMEOUT cycles after it
          state <= WAIT;
          wd    <= wd_nxt[TIMEOUT_W-1:0];
        end
        WAIT: begin
          wd <= wd_nxt[TIMEOUT_W-1:0];
          if (bus_done) begin
            state <= IDLE;
            if (grant) begin
              m1_q    <= bus_q;
              m1_done <= 1'b1;
            end else begin
              m0_q    <= bus_q;
              m0_done <= 1'b1;
            end
          end else if (to_hit) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            if (grant) begin
              m1_q    <= '0;
              m1_done <= 1'b1;
            end else begin
              m0_q    <= '0;
              m0_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // a master's pending bit is never cleared and set
      // in the same cycle: capture needs it already clear
      if (m0_start && !pending[0]) begin
        h_addr[0]  <= m0_addr;
        h_data[0]  <= m0_data;
        h_we[0]    <= m0_we;
        pending[0] <= 1'b1;
      end
      if (m1_start && !pending[1]) begin
        h_addr[1]  <= m1_addr;
        h_data[1]  <= m1_data;
        h_we[1]    <= m1_we;
        pending[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic [26:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_data = '0, m1_data = '0;
  logic        m0_we = 0, m1_we = 0;
  logic        m0_start = 0, m1_start = 0;
  logic [31:0] m0_q, m1_q;
  logic        m0_done, m1_done;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we, bus_start;
  logic [31:0] bus_q = '0;
  logic        bus_done = 0;
  logic        grant, timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bus_arbiter #(
    .TIMEOUT(8),
    .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .nreset(nreset),
    .m0_addr(m0_addr), .m0_data(m0_data),
    .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(m0_q), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_data(m1_data),
    .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(m1_q), .m1_done(m1_done),
    .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $display("FAIL %s: got %h, want %h",
               tag, obs, want);
      $error("%s got %h want %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input int m, input logic s,
                     input logic [26:0] a,
                     input logic [31:0] d,
                     input logic w);
    if (m == 0) begin
      m0_start = s; m0_addr = a;
      m0_data = d;  m0_we = w;
    end else begin
      m1_start = s; m1_addr = a;
      m1_data = d;  m1_we = w;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_baddr"}, 32'(bus_addr), 0);
    chk({p, "_bdata"}, bus_data, 0);
    chk({p, "_bwe"}, 32'(bus_we), 0);
    chk({p, "_bstart"}, 32'(bus_start), 0);
    chk({p, "_q0"}, m0_q, 0);
    chk({p, "_q1"}, m1_q, 0);
    chk({p, "_d0"}, 32'(m0_done), 0);
    chk({p, "_d1"}, 32'(m1_done), 0);
    chk({p, "_grant"}, 32'(grant), 0);
    chk({p, "_terr"}, 32'(timeout_err), 0);
  endtask

  task automatic do_reset(input string p);
    drv(0, 0, '0, '0, 0);
    drv(1, 0, '0, '0, 0);
    bus_done = 0;
    nreset = 0;
    #2;
    chk_zero(p);
    tick();
    nreset = 1;
  endtask

  // bench acts as slave: done after lat cycles
  task automatic serve(input int lat,
                       input logic [31:0] q);
    repeat (lat) tick();
    bus_done = 1;
    bus_q = q;
    tick();
    bus_done = 0;
  endtask

  // randomized-phase model state
  logic        rv [2], ris [2], rw [2];
  logic [26:0] ra [2];
  logic [31:0] rd [2], eq [2];
  int          rc [2];
  logic        act, tmo, lastg, own, w;
  logic        el0, el1, ebs, ed0, ed1, ete;
  int          bcyc, rsp, free_c;
  logic [31:0] rq;

  initial begin
    #2;
    do_reset("rst");

    // single read from m0
    drv(0, 1, 27'h000100, 32'h0, 0);
    tick();
    m0_start = 0;
    chk("t1_bs_early", 32'(bus_start), 0);
    tick();
    chk("t1_bs", 32'(bus_start), 1);
    chk("t1_addr", 32'(bus_addr), 32'h100);
    chk("t1_we", 32'(bus_we), 0);
    chk("t1_grant", 32'(grant), 0);
    serve(3, 32'hCAFEBABE);
    chk("t1_d0", 32'(m0_done), 1);
    chk("t1_q0", m0_q, 32'hCAFEBABE);
    chk("t1_d1", 32'(m1_done), 0);
    tick();
    chk("t1_d0_off", 32'(m0_done), 0);
    chk("t1_q0_hold", m0_q, 32'hCAFEBABE);

    // tie after reset: m0 first, then alternate
    do_reset("rst2");
    drv(0, 1, 27'h10, 32'h1, 0);
    drv(1, 1, 27'h20, 32'h2, 0);
    tick();
    m0_start = 0; m1_start = 0;
    tick();
    chk("t2_bs_a", 32'(bus_start), 1);
    chk("t2_grant_a", 32'(grant), 0);
    chk("t2_addr_a", 32'(bus_addr), 32'h10);
    serve(2, 32'h111);
    chk("t2_d0", 32'(m0_done), 1);
    chk("t2_d1_off", 32'(m1_done), 0);
    tick();
    chk("t2_bs_b", 32'(bus_start), 1);
    chk("t2_grant_b", 32'(grant), 1);
    chk("t2_addr_b", 32'(bus_addr), 32'h20);
    serve(1, 32'h222);
    chk("t2_d1", 32'(m1_done), 1);
    chk("t2_q1", m1_q, 32'h222);
    chk("t2_q0_hold", m0_q, 32'h111);
    drv(0, 1, 27'h30, 32'h3, 0);
    drv(1, 1, 27'h40, 32'h4, 0);
    tick();
    m0_start = 0; m1_start = 0;
    tick();
    chk("t2_grant_c", 32'(grant), 0);
    chk("t2_addr_c", 32'(bus_addr), 32'h30);
    serve(1, 32'h333);
    tick();
    chk("t2_grant_d", 32'(grant), 1);
    chk("t2_addr_d", 32'(bus_addr), 32'h40);
    serve(1, 32'h444);
    chk("t2_q1_d", m1_q, 32'h444);

    // m1 posts while m0 is in WAIT
    drv(0, 1, 27'h200, 32'hAAAA0000, 0);
    tick();
    m0_start = 0;
    tick();
    chk("t3_bs_a", 32'(bus_start), 1);
    tick();
    drv(1, 1, 27'h0000FF, 32'h12345678, 1);
    tick();
    m1_start = 0;
    chk("t3_addr_hold", 32'(bus_addr), 32'h200);
    chk("t3_data_hold", bus_data, 32'hAAAA0000);
    chk("t3_bs_off", 32'(bus_start), 0);
    tick();
    chk("t3_grant_hold", 32'(grant), 0);
    bus_done = 1;
    bus_q = 32'h5555;
    tick();
    bus_done = 0;
    chk("t3_d0", 32'(m0_done), 1);
    chk("t3_q0", m0_q, 32'h5555);
    chk("t3_bs_gap", 32'(bus_start), 0);
    tick();
    chk("t3_bs_b", 32'(bus_start), 1);
    chk("t3_grant_b", 32'(grant), 1);
    chk("t3_addr_b", 32'(bus_addr), 32'hFF);
    chk("t3_data_b", bus_data, 32'h12345678);
    chk("t3_we_b", 32'(bus_we), 1);
    serve(2, 32'h0);
    chk("t3_d1", 32'(m1_done), 1);

    // duplicate start while pending
    drv(0, 1, 27'h300, 32'h0, 0);
    tick();
    drv(0, 1, 27'h301, 32'h9, 1);
    tick();
    m0_start = 0;
    chk("t4_bs", 32'(bus_start), 1);
    chk("t4_addr", 32'(bus_addr), 32'h300);
    chk("t4_we", 32'(bus_we), 0);
    serve(2, 32'h777);
    chk("t4_d0", 32'(m0_done), 1);
    chk("t4_q0", m0_q, 32'h777);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_bs_extra", 32'(bus_start), 0);
      chk("t4_d0_extra", 32'(m0_done), 0);
    end

    // watchdog abort, then a late done
    drv(0, 1, 27'h400, 32'h0, 0);
    tick();
    m0_start = 0;
    tick();
    chk("t5_bs", 32'(bus_start), 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t5_d0_early", 32'(m0_done), 0);
      chk("t5_terr_early", 32'(timeout_err), 0);
    end
    tick();
    chk("t5_d0", 32'(m0_done), 1);
    chk("t5_terr", 32'(timeout_err), 1);
    chk("t5_q0", m0_q, 32'h0);
    bus_done = 1;
    bus_q = 32'hDEADBEEF;
    tick();
    bus_done = 0;
    chk("t5_late_d0", 32'(m0_done), 0);
    chk("t5_late_terr", 32'(timeout_err), 0);
    chk("t5_late_q0", m0_q, 32'h0);
    chk("t5_late_d1", 32'(m1_done), 0);

    // done on the last cycle before abort wins
    drv(1, 1, 27'h500, 32'h1, 0);
    tick();
    m1_start = 0;
    tick();
    chk("t5b_grant", 32'(grant), 1);
    serve(7, 32'hBEEF);
    chk("t5b_d1", 32'(m1_done), 1);
    chk("t5b_terr", 32'(timeout_err), 0);
    chk("t5b_q1", m1_q, 32'hBEEF);

    // reset in the middle of WAIT
    drv(0, 1, 27'h600, 32'h0, 0);
    tick();
    m0_start = 0;
    tick();
    tick();
    tick();
    nreset = 0;
    #1;
    chk_zero("t6");
    bus_done = 1;
    tick();
    nreset = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus_done = 0;
      chk("t6_d0", 32'(m0_done), 0);
      chk("t6_bs", 32'(bus_start), 0);
    end
    drv(1, 1, 27'h700, 32'h7, 1);
    tick();
    m1_start = 0;
    tick();
    chk("t6_bs_new", 32'(bus_start), 1);
    chk("t6_grant", 32'(grant), 1);
    chk("t6_addr", 32'(bus_addr), 32'h700);
    serve(1, 32'h42);
    chk("t6_d1", 32'(m1_done), 1);
    chk("t6_q1", m1_q, 32'h42);

    // randomized traffic against the model
    do_reset("rst3");
    for (int m = 0; m < 2; m++) begin
      rv[m] = 0; ris[m] = 0; eq[m] = '0;
      ra[m] = '0; rd[m] = '0; rw[m] = 0;
      rc[m] = 0;
    end
    act = 0; tmo = 0; lastg = 1; own = 0;
    bcyc = 0; rsp = 0; free_c = 0; rq = '0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      ed0 = 0; ed1 = 0; ete = 0;
      if (act &&
          cyc == (tmo ? bcyc + 8 : rsp + 1)) begin
        if (own) ed1 = 1;
        else ed0 = 1;
        ete = tmo;
        eq[own] = tmo ? 32'h0 : rq;
        rv[own] = 0;
        ris[own] = 0;
        act = 0;
        free_c = cyc + 1;
      end
      chk("r_d0", 32'(m0_done), 32'(ed0));
      chk("r_d1", 32'(m1_done), 32'(ed1));
      chk("r_terr", 32'(timeout_err), 32'(ete));
      chk("r_q0", m0_q, eq[0]);
      chk("r_q1", m1_q, eq[1]);

      el0 = rv[0] && !ris[0] && rc[0] <= cyc - 2;
      el1 = rv[1] && !ris[1] && rc[1] <= cyc - 2;
      ebs = !act && cyc >= free_c && (el0 || el1);
      chk("r_bs", 32'(bus_start), 32'(ebs));
      if (ebs) begin
        w = (el0 && el1) ? !lastg : el1;
        ris[w] = 1;
        act = 1;
        own = w;
        lastg = w;
        bcyc = cyc;
        tmo = ($urandom_range(0, 7) == 0);
        rsp = cyc + $urandom_range(1, 7);
        rq = $urandom;
      end
      if (act) begin
        chk("r_grant", 32'(grant), 32'(own));
        chk("r_addr", 32'(bus_addr), 32'(ra[own]));
        chk("r_data", bus_data, rd[own]);
        chk("r_we", 32'(bus_we), 32'(rw[own]));
      end

      bus_done = act && !tmo && cyc == rsp;
      bus_q = bus_done ? rq : $urandom;
      if ((!act || cyc == bcyc) &&
          $urandom_range(0, 5) == 0)
        bus_done = 1;
      for (int m = 0; m < 2; m++) begin
        if (!rv[m] && $urandom_range(0, 2) == 0) begin
          rv[m] = 1;
          ris[m] = 0;
          ra[m] = 27'($urandom);
          rd[m] = $urandom;
          rw[m] = 1'($urandom);
          rc[m] = cyc;
          drv(m, 1, ra[m], rd[m], rw[m]);
        end else if (rv[m] && !ris[m] &&
                     $urandom_range(0, 3) == 0) begin
          drv(m, 1, 27'($urandom), $urandom,
              1'($urandom));
        end else begin
          drv(m, 0, 27'($urandom), $urandom,
              1'($urandom));
        end
      end
    end

    drv(0, 0, '0, '0, 0);
    drv(1, 0, '0, '0, 0);
    bus_done = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
